// File: rtl/id_ex_pkg.sv
// Shared definitions for the ID->EX skid stage: control bundle layout,
// load detection and the occupancy state encoding.
package id_ex_pkg;

  localparam int CTRL_W = 10;

  // Bit positions inside the packed control bundle
  localparam int REGWRITE     = 0;
  localparam int MEMWRITE     = 1;
  localparam int BRANCH       = 2;
  localparam int JUMP         = 3;
  localparam int ALUSRC       = 4;
  localparam int RESULTSRC_LO = 5;
  localparam int RESULTSRC_HI = 6;
  localparam int ALUCTRL_LO   = 7;
  localparam int ALUCTRL_HI   = 9;

  localparam logic [1:0] RESULTSRC_LOAD = 2'b01;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  function automatic logic is_load(input logic [1:0] resultsrc);
    return resultsrc == RESULTSRC_LOAD;
  endfunction

endpackage

// File: rtl/id_ex_hazard_unit.sv
// Load-use compare between the youngest in-flight instruction and the
// instruction currently offered by decode.
module id_ex_hazard_unit #(
  parameter int REG_AW = 5
) (
  input  logic              id_valid,
  input  logic              youngest_valid,
  input  logic              youngest_load,
  input  logic [REG_AW-1:0] youngest_rd,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  output logic              hazard
);

  // x0 is never a real destination, so a load into it cannot create a dependency
  assign hazard = id_valid & youngest_valid & youngest_load &
                  (youngest_rd != '0) &
                  ((youngest_rd == id_rs1) | (youngest_rd == id_rs2));

endmodule

// File: rtl/id_ex_skid_stage.sv
// ID->EX valid/ready boundary with a two-entry skid buffer, load-use interlock
// and flush. Optional performance counters are enabled by ID_EX_PERF_CNT_EN.
module id_ex_skid_stage
  import id_ex_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = id_ex_pkg::CTRL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_pc_plus4,
  input  logic [XLEN-1:0]   id_rd1,
  input  logic [XLEN-1:0]   id_rd2,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [CTRL_W-1:0] id_ctrl,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_pc_plus4,
  output logic [XLEN-1:0]   ex_rd1,
  output logic [XLEN-1:0]   ex_rd2,
  output logic [XLEN-1:0]   ex_imm,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [REG_AW-1:0] ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  input  logic              flush,
  output logic              hazard_stall
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt,
  output logic [31:0]       perf_bubble_cnt
`endif
);

  localparam int PW = 5 * XLEN + 3 * REG_AW + CTRL_W;

  occ_e            state_q, state_d;
  logic [PW-1:0]   main_q, main_d;
  logic [PW-1:0]   skid_q, skid_d;
  logic [PW-1:0]   id_payload;
  logic [CTRL_W-1:0] main_ctrl;
  logic            main_valid, skid_valid;
  logic            accept, consume, hazard;
  logic [REG_AW-1:0] young_rd;
  logic [1:0]      young_resultsrc;

  assign id_payload = {id_pc, id_pc_plus4, id_rd1, id_rd2, id_imm,
                       id_rs1, id_rs2, id_rd, id_ctrl};

  assign main_valid = (state_q != EMPTY);
  assign skid_valid = (state_q == TWO);

  // The skid entry, when present, is always the younger of the two
  assign young_rd        = skid_valid ? skid_q[CTRL_W +: REG_AW] : main_q[CTRL_W +: REG_AW];
  assign young_resultsrc = skid_valid ? skid_q[RESULTSRC_HI:RESULTSRC_LO]
                                      : main_q[RESULTSRC_HI:RESULTSRC_LO];

  id_ex_hazard_unit #(.REG_AW(REG_AW)) u_hazard (
    .id_valid      (id_valid),
    .youngest_valid(main_valid),
    .youngest_load (is_load(young_resultsrc)),
    .youngest_rd   (young_rd),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .hazard        (hazard)
  );

  assign hazard_stall = hazard;
  assign id_ready     = rst & ~skid_valid & ~hazard & ~flush;
  assign accept       = id_valid & id_ready;
  assign consume      = main_valid & ex_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_d  = id_payload;
            state_d = ONE;
          end
        end
        ONE: begin
          if (accept && !consume) begin
            skid_d  = id_payload;
            state_d = TWO;
          end else if (accept && consume) begin
            main_d  = id_payload;
          end else if (consume) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (consume) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign {ex_pc, ex_pc_plus4, ex_rd1, ex_rd2, ex_imm,
          ex_rs1, ex_rs2, ex_rd, main_ctrl} = main_q;
  assign ex_valid = main_valid;
  // Stale control left behind by a flush or drain must never look live to EX
  assign ex_ctrl  = main_valid ? main_ctrl : '0;

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;
  logic [31:0] perf_bubble_q, perf_bubble_d;

  always_comb begin
    perf_stall_d  = perf_stall_q  + {31'd0, hazard};
    perf_flush_d  = perf_flush_q  + {31'd0, flush};
    perf_bubble_d = perf_bubble_q + {31'd0, ~main_valid & ~flush};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_q  <= '0;
      perf_flush_q  <= '0;
      perf_bubble_q <= '0;
    end else begin
      perf_stall_q  <= perf_stall_d;
      perf_flush_q  <= perf_flush_d;
      perf_bubble_q <= perf_bubble_d;
    end
  end

  assign perf_stall_cnt  = perf_stall_q;
  assign perf_flush_cnt  = perf_flush_q;
  assign perf_bubble_cnt = perf_bubble_q;
`endif

endmodule

// File: tb/tb_id_ex_skid_stage.sv
// Scoreboard bench for id_ex_skid_stage: a queue-of-instructions model predicts
// acceptance and stalls; a negedge monitor checks every cycle of EX output.
module tb_id_ex_skid_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        id_valid = 1'b0;
  logic        id_ready;
  logic [31:0] id_pc = '0, id_pc_plus4 = '0, id_rd1 = '0, id_rd2 = '0, id_imm = '0;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic [9:0]  id_ctrl = '0;
  logic        ex_valid;
  logic        ex_ready = 1'b0;
  logic [31:0] ex_pc, ex_pc_plus4, ex_rd1, ex_rd2, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [9:0]  ex_ctrl;
  logic        flush = 1'b0;
  logic        hazard_stall;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt, perf_bubble_cnt;
`endif

  always #5 clk = ~clk;

  id_ex_skid_stage dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_pc_plus4(id_pc_plus4), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_ctrl(id_ctrl),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_pc(ex_pc), .ex_pc_plus4(ex_pc_plus4), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
    .flush(flush), .hazard_stall(hazard_stall)
`ifdef ID_EX_PERF_CNT_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt),
    .perf_bubble_cnt(perf_bubble_cnt)
`endif
  );

  // ctrl layout: [6:5] = result source, 2'b01 means load
  localparam logic [9:0] CTRL_LOAD = 10'b000_01_1_0_0_0_1;
  localparam logic [9:0] CTRL_ALU  = 10'b010_00_0_0_0_0_1;

  typedef struct {
    logic [31:0] pc, pc4, rd1, rd2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [9:0]  ctrl;
    int          cyc;
  } instr_t;

  instr_t exp_q[$];
  int     cyc = 0;
  int     errors = 0;
  int     checks = 0;
  logic   exp_ready = 1'b0;
  logic   exp_hazard = 1'b0;
  int     m_stall = 0, m_flush = 0, m_bubble = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Reference model: the stage holds at most two in-flight instructions in
  // program order; a load at the tail blocks a dependent decode instruction.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #3;
      if (!rst) begin
        exp_q.delete();
        exp_ready  = 1'b0;
        exp_hazard = 1'b0;
        m_stall = 0; m_flush = 0; m_bubble = 0;
      end else begin
        int n;
        n = exp_q.size();
        exp_hazard = id_valid && n > 0 && exp_q[n-1].ctrl[6:5] == 2'b01 &&
                     exp_q[n-1].rd != 5'd0 &&
                     (exp_q[n-1].rd == id_rs1 || exp_q[n-1].rd == id_rs2);
        exp_ready  = (n < 2) && !exp_hazard && !flush;
        m_stall  += int'(exp_hazard);
        m_flush  += int'(flush);
        m_bubble += int'(n == 0 && !flush);
        if (id_valid && exp_ready) begin
          instr_t t;
          t.pc = id_pc; t.pc4 = id_pc_plus4; t.rd1 = id_rd1; t.rd2 = id_rd2; t.imm = id_imm;
          t.rs1 = id_rs1; t.rs2 = id_rs2; t.rd = id_rd; t.ctrl = id_ctrl; t.cyc = cyc;
          exp_q.push_back(t);
        end
      end
    end
  end

  // Monitor: compares DUT outputs mid-cycle, then retires consumed/flushed entries
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_id_ready", {31'd0, id_ready}, 32'd0);
        chk("rst_hazard", {31'd0, hazard_stall}, 32'd0);
        chk("rst_ex_ctrl", {22'd0, ex_ctrl}, 32'd0);
        chk("rst_ex_pc", ex_pc, 32'd0);
        chk("rst_ex_rd", {27'd0, ex_rd}, 32'd0);
      end else begin
        logic vis;
        vis = exp_q.size() > 0 && exp_q[0].cyc < cyc;
        chk("ex_valid", {31'd0, ex_valid}, {31'd0, vis});
        chk("id_ready", {31'd0, id_ready}, {31'd0, exp_ready});
        chk("hazard_stall", {31'd0, hazard_stall}, {31'd0, exp_hazard});
        if (vis) begin
          chk("ex_pc", ex_pc, exp_q[0].pc);
          chk("ex_pc_plus4", ex_pc_plus4, exp_q[0].pc4);
          chk("ex_rd1", ex_rd1, exp_q[0].rd1);
          chk("ex_rd2", ex_rd2, exp_q[0].rd2);
          chk("ex_imm", ex_imm, exp_q[0].imm);
          chk("ex_regs", {17'd0, ex_rs1, ex_rs2, ex_rd},
              {17'd0, exp_q[0].rs1, exp_q[0].rs2, exp_q[0].rd});
          chk("ex_ctrl", {22'd0, ex_ctrl}, {22'd0, exp_q[0].ctrl});
          $display("cyc=%0d EX pc=%h ctrl=%h ready=%0d flush=%0d", cyc, ex_pc, ex_ctrl, ex_ready, flush);
        end else begin
          chk("idle_ex_ctrl", {22'd0, ex_ctrl}, 32'd0);
        end
        if (flush) exp_q.delete();
        else if (vis && ex_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic step(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [4:0] rd, input logic [9:0] ctrl,
                      input logic exr, input logic fl);
    @(posedge clk);
    #1;
    id_valid = v; id_pc = pc; id_pc_plus4 = pc + 32'd4;
    id_rd1 = $urandom; id_rd2 = $urandom; id_imm = $urandom;
    id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_ctrl = ctrl;
    ex_ready = exr; flush = fl;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 10'd0, 1'b1, 1'b0);
  endtask

  // Hold reset low for n cycles; decode offers pc 0x100 in the release cycle
  task automatic reset_then_issue(input int n);
    @(posedge clk);
    #1;
    rst = 1'b0; id_valid = 1'b0; flush = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b1;
    id_valid = 1'b1; id_pc = 32'h100; id_pc_plus4 = 32'h104; id_rs1 = 5'd1; id_rs2 = 5'd2;
    id_rd = 5'd3; id_ctrl = CTRL_ALU; ex_ready = 1'b1; flush = 1'b0;
  endtask

  initial begin
    reset_then_issue(2);
    idle(2);

    // backpressure: fill both entries, drain in order
    step(1'b1, 32'h0, 5'd1, 5'd2, 5'd3, CTRL_ALU, 1'b0, 1'b0);
    step(1'b1, 32'h4, 5'd1, 5'd2, 5'd4, CTRL_ALU, 1'b0, 1'b0);
    step(1'b1, 32'h8, 5'd1, 5'd2, 5'd6, CTRL_ALU, 1'b0, 1'b0);
    idle(3);

    // load-use: one stall, one bubble
    step(1'b1, 32'h20, 5'd1, 5'd2, 5'd5, CTRL_LOAD, 1'b1, 1'b0);
    step(1'b1, 32'h24, 5'd5, 5'd7, 5'd8, CTRL_ALU, 1'b1, 1'b0);
    step(1'b1, 32'h24, 5'd5, 5'd7, 5'd8, CTRL_ALU, 1'b1, 1'b0);
    idle(2);

    // x0 load never interlocks
    step(1'b1, 32'h30, 5'd1, 5'd2, 5'd0, CTRL_LOAD, 1'b1, 1'b0);
    step(1'b1, 32'h34, 5'd0, 5'd0, 5'd9, CTRL_ALU, 1'b1, 1'b0);
    idle(2);

    // flush beats consume and accept while full
    step(1'b1, 32'h40, 5'd1, 5'd2, 5'd3, CTRL_ALU, 1'b0, 1'b0);
    step(1'b1, 32'h44, 5'd1, 5'd2, 5'd4, CTRL_ALU, 1'b0, 1'b0);
    step(1'b1, 32'h48, 5'd1, 5'd2, 5'd6, CTRL_ALU, 1'b1, 1'b1);
    idle(2);

    // reset mid-stream with entries in flight
    step(1'b1, 32'h50, 5'd1, 5'd2, 5'd3, CTRL_ALU, 1'b0, 1'b0);
    step(1'b1, 32'h54, 5'd1, 5'd2, 5'd4, CTRL_ALU, 1'b0, 1'b0);
    step(1'b1, 32'h58, 5'd1, 5'd2, 5'd6, CTRL_ALU, 1'b0, 1'b0);
    reset_then_issue(2);
    idle(2);

    // randomized traffic with small register indices to provoke hazards
    for (int i = 0; i < 1500; i++) begin
      logic [9:0] c;
      c = 10'($urandom);
      step(1'($urandom_range(0, 9) < 7), 32'($urandom) & 32'hffff_fffc,
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           c, 1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 99) < 6));
    end
    idle(3);

`ifdef ID_EX_PERF_CNT_EN
    // counter scenario from a clean reset: load-use then a single flush
    reset_then_issue(2);
    step(1'b1, 32'h200, 5'd1, 5'd2, 5'd5, CTRL_LOAD, 1'b1, 1'b0);
    step(1'b1, 32'h204, 5'd5, 5'd0, 5'd6, CTRL_ALU, 1'b1, 1'b0);
    step(1'b1, 32'h204, 5'd5, 5'd0, 5'd6, CTRL_ALU, 1'b1, 1'b0);
    step(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 10'd0, 1'b1, 1'b1);
    idle(2);
    @(posedge clk);
    #2;
    chk("perf_stall_cnt", perf_stall_cnt, 32'(m_stall));
    chk("perf_flush_cnt", perf_flush_cnt, 32'(m_flush));
    chk("perf_bubble_cnt", perf_bubble_cnt, 32'(m_bubble));
    chk("perf_stall_is_1", perf_stall_cnt, 32'd1);
    chk("perf_flush_is_1", perf_flush_cnt, 32'd1);
`endif

    idle(1);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
